// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and a twoPortMem (slave).
// One write port and one read port sharing the controller clock.
interface mem_bist_ctrl_if #(
   parameter int addressWidth = 5,
   parameter int width        = 8
);
   logic [addressWidth-1:0] writeAddress;
   logic                    writeEnable;
   logic [width-1:0]        writeData;
   logic [addressWidth-1:0] readAddress;
   logic                    readEnable;
   logic [width-1:0]        readData;

   modport master (
      output writeAddress, writeEnable, writeData, readAddress, readEnable,
      input  readData
   );

   modport slave (
      input  writeAddress, writeEnable, writeData, readAddress, readEnable,
      output readData
   );
endinterface

// File: rtl/mem_bist_ctrl.sv
// March C- BIST controller for a twoPortMem: drives both ports, checks read data,
// stops on the first mismatch and reports its address and march element.
module mem_bist_ctrl #(
   parameter  int addresses    = 32,
   parameter  int width        = 8,
   localparam int addressWidth = $clog2(addresses)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    fail,
   output logic [addressWidth-1:0] failAddress,
   output logic [2:0]              failPhase,
   mem_bist_ctrl_if.master         mem
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef enum logic [2:0] {
      W0Up     = 3'd0,
      R0W1Up   = 3'd1,
      R1W0Up   = 3'd2,
      R0W1Down = 3'd3,
      R1W0Down = 3'd4,
      R0Down   = 3'd5
   } elem_t;

   localparam logic [addressWidth-1:0] lastAddr = addressWidth'(addresses - 1);
   localparam logic [addressWidth-1:0] one      = addressWidth'(1);

   state_t                  state, stateNext;
   elem_t                   elem, elemNext;
   logic [addressWidth-1:0] addr, addrNext;
   logic                    stepB, stepBNext;
   logic [addressWidth-1:0] wrAddrQ, rdAddrQ;
   logic [width-1:0]        wrDataQ;

   logic             wrEn, rdEn, compare, mismatch, startRun;
   logic [width-1:0] wrPattern, expected;

   always_comb begin
      stateNext = state;
      elemNext  = elem;
      addrNext  = addr;
      stepBNext = stepB;
      wrEn      = 1'b0;
      rdEn      = 1'b0;
      compare   = 1'b0;
      startRun  = 1'b0;
      wrPattern = '0;
      expected  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = RUN;
               elemNext  = W0Up;
               addrNext  = '0;
               stepBNext = 1'b0;
               startRun  = 1'b1;
            end
         end
         RUN: begin
            case (elem)
               W0Up: begin
                  wrEn = 1'b1;
                  if (addr == lastAddr) begin
                     elemNext = R0W1Up;
                     addrNext = '0;
                  end else begin
                     addrNext = addr + one;
                  end
               end
               // Compare trails the read by one cycle, so the first read has nothing to check yet.
               R0Down: begin
                  rdEn    = 1'b1;
                  compare = (addr != lastAddr);
                  if (addr == '0) stateNext = DRAIN;
                  else            addrNext  = addr - one;
               end
               default: begin
                  if (!stepB) begin
                     rdEn      = 1'b1;
                     stepBNext = 1'b1;
                  end else begin
                     wrEn      = 1'b1;
                     compare   = 1'b1;
                     stepBNext = 1'b0;
                     expected  = (elem == R1W0Up || elem == R1W0Down) ? '1 : '0;
                     wrPattern = ~expected;
                     if (elem == R0W1Up || elem == R1W0Up) begin
                        if (addr == lastAddr) begin
                           elemNext = (elem == R0W1Up) ? R1W0Up : R0W1Down;
                           addrNext = (elem == R0W1Up) ? '0 : lastAddr;
                        end else begin
                           addrNext = addr + one;
                        end
                     end else begin
                        if (addr == '0) begin
                           elemNext = (elem == R0W1Down) ? R1W0Down : R0Down;
                           addrNext = lastAddr;
                        end else begin
                           addrNext = addr - one;
                        end
                     end
                  end
               end
            endcase
         end
         DRAIN: begin
            compare   = 1'b1;
            stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      mismatch = compare && (mem.readData != expected);
      if (mismatch) stateNext = DONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         elem        <= W0Up;
         addr        <= '0;
         stepB       <= 1'b0;
         wrAddrQ     <= '0;
         rdAddrQ     <= '0;
         wrDataQ     <= '0;
         done        <= 1'b0;
         fail        <= 1'b0;
         failAddress <= '0;
         failPhase   <= '0;
      end else begin
         state <= stateNext;
         elem  <= elemNext;
         addr  <= addrNext;
         stepB <= stepBNext;
         if (wrEn) begin
            wrAddrQ <= addr;
            wrDataQ <= wrPattern;
         end
         if (rdEn) rdAddrQ <= addr;
         // rdAddrQ always names the read whose data is being compared this cycle.
         if (startRun) begin
            done        <= 1'b0;
            fail        <= 1'b0;
            failAddress <= '0;
            failPhase   <= '0;
         end else if (mismatch) begin
            done        <= 1'b1;
            fail        <= 1'b1;
            failAddress <= rdAddrQ;
            failPhase   <= elem;
         end else if (state == DRAIN) begin
            done <= 1'b1;
         end
      end
   end

   assign busy             = (state == RUN) || (state == DRAIN);
   assign mem.writeEnable  = wrEn;
   assign mem.readEnable   = rdEn;
   assign mem.writeAddress = wrEn ? addr : wrAddrQ;
   assign mem.writeData    = wrEn ? wrPattern : wrDataQ;
   assign mem.readAddress  = rdEn ? addr : rdAddrQ;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (32 and 20 words) each beside a behavioural
// two-port memory; the 32-word memory can inject stuck-at and alias faults.
module tb_mem_bist_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic start0, start1;
   logic busy0, done0, fail0, busy1, done1, fail1;
   logic [4:0] failAddress0, failAddress1;
   logic [2:0] failPhase0, failPhase1;
   int total = 0;
   int bad   = 0;
   int faultMode = 0;
   logic sel = 1'b0;

   always #5 clk = ~clk;

   mem_bist_ctrl_if #(.addressWidth(5), .width(8)) bus0 ();
   mem_bist_ctrl_if #(.addressWidth(5), .width(8)) bus1 ();

   mem_bist_ctrl #(.addresses(32), .width(8)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
      .failAddress(failAddress0), .failPhase(failPhase0), .mem(bus0)
   );
   mem_bist_ctrl #(.addresses(20), .width(8)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
      .failAddress(failAddress1), .failPhase(failPhase1), .mem(bus1)
   );

   // Memory models: registered read, one-cycle latency
   logic [7:0] mem0 [32];
   logic [7:0] mem1 [20];
   logic [7:0] rdq0, rdq1, rd0;
   logic [4:0] rdA0;

   always @(posedge clk) begin
      if (bus0.writeEnable) begin
         mem0[bus0.writeAddress] <= bus0.writeData;
         if (faultMode == 3 && bus0.writeAddress == 5'd3) mem0[4] <= bus0.writeData;
      end
      if (bus0.readEnable) begin
         rdq0 <= mem0[bus0.readAddress];
         rdA0 <= bus0.readAddress;
      end
      if (bus1.writeEnable && bus1.writeAddress < 5'd20) mem1[bus1.writeAddress] <= bus1.writeData;
      if (bus1.readEnable) rdq1 <= (bus1.readAddress < 5'd20) ? mem1[bus1.readAddress] : 8'hxx;
   end

   always_comb begin
      rd0 = rdq0;
      if (faultMode == 1 && rdA0 == 5'd5) rd0[0] = 1'b1;
      if (faultMode == 2 && rdA0 == 5'd7) rd0[3] = 1'b0;
   end
   assign bus0.readData = rd0;
   assign bus1.readData = rdq1;

   logic sBusy, sDone, sFail, sWe, sRe;
   logic [4:0] sFa, sWa, sRa;
   logic [2:0] sFp;
   logic [7:0] sWd;
   always_comb begin
      if (!sel) begin
         sBusy = busy0; sDone = done0; sFail = fail0; sFa = failAddress0; sFp = failPhase0;
         sWe = bus0.writeEnable; sRe = bus0.readEnable; sWa = bus0.writeAddress;
         sRa = bus0.readAddress; sWd = bus0.writeData;
      end else begin
         sBusy = busy1; sDone = done1; sFail = fail1; sFa = failAddress1; sFp = failPhase1;
         sWe = bus1.writeEnable; sRe = bus1.readEnable; sWa = bus1.writeAddress;
         sRa = bus1.readAddress; sWd = bus1.writeData;
      end
   end

   task automatic setStart(input logic v);
      if (!sel) start0 = v;
      else      start1 = v;
   endtask

   // Leaves the caller at the negedge of the first cycle after start was sampled
   task automatic pulseStart();
      @(negedge clk);
      setStart(1'b1);
      @(negedge clk);
      setStart(1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({sBusy, sDone, sFail, sWe, sRe} !== 5'b0 || sFa !== 5'd0 || sFp !== 3'd0 ||
          sWa !== 5'd0 || sRa !== 5'd0 || sWd !== 8'd0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b fail=%b we=%b re=%b fa=%0d fp=%0d wa=%0d ra=%0d wd=%h, need all 0",
                  sBusy, sDone, sFail, sWe, sRe, sFa, sFp, sWa, sRa, sWd);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Clean run: checks every busy cycle against the March C- access order
   task automatic test_clean(input int n, input int restartAt, input string tag);
      logic [19:0] expQ[$];
      logic [19:0] e;
      int cycles = 0;
      int guard = 0;
      int maxAddr = 0;
      for (int a = 0; a < n; a++) expQ.push_back({1'b1, 5'(a), 8'h00, 1'b0, 5'd0});
      for (int a = 0; a < n; a++) begin
         expQ.push_back({1'b0, 5'd0, 8'h00, 1'b1, 5'(a)});
         expQ.push_back({1'b1, 5'(a), 8'hFF, 1'b0, 5'd0});
      end
      for (int a = 0; a < n; a++) begin
         expQ.push_back({1'b0, 5'd0, 8'h00, 1'b1, 5'(a)});
         expQ.push_back({1'b1, 5'(a), 8'h00, 1'b0, 5'd0});
      end
      for (int a = n - 1; a >= 0; a--) begin
         expQ.push_back({1'b0, 5'd0, 8'h00, 1'b1, 5'(a)});
         expQ.push_back({1'b1, 5'(a), 8'hFF, 1'b0, 5'd0});
      end
      for (int a = n - 1; a >= 0; a--) begin
         expQ.push_back({1'b0, 5'd0, 8'h00, 1'b1, 5'(a)});
         expQ.push_back({1'b1, 5'(a), 8'h00, 1'b0, 5'd0});
      end
      for (int a = n - 1; a >= 0; a--) expQ.push_back({1'b0, 5'd0, 8'h00, 1'b1, 5'(a)});
      expQ.push_back(20'd0);

      pulseStart();
      total++;
      if (sBusy !== 1'b1 || sDone !== 1'b0 || sFail !== 1'b0 || sFa !== 5'd0 || sFp !== 3'd0) begin
         bad++;
         $display("FAIL %s_start_state: got busy=%b done=%b fail=%b fa=%0d fp=%0d, need 1 0 0 0 0",
                  tag, sBusy, sDone, sFail, sFa, sFp);
      end
      while (sBusy === 1'b1 && guard < 2000) begin
         e = (cycles < expQ.size()) ? expQ[cycles] : 20'hFFFFF;
         total++;
         if (sWe !== e[19] || sRe !== e[5] || (e[19] && (sWa !== e[18:14] || sWd !== e[13:6])) ||
             (e[5] && sRa !== e[4:0])) begin
            bad++;
            $display("FAIL %s_seq cycle %0d: got we=%b wa=%0d wd=%h re=%b ra=%0d, need we=%b wa=%0d wd=%h re=%b ra=%0d",
                     tag, cycles, sWe, sWa, sWd, sRe, sRa, e[19], e[18:14], e[13:6], e[5], e[4:0]);
         end
         if (sWe === 1'b1 && int'(sWa) > maxAddr) maxAddr = int'(sWa);
         if (sRe === 1'b1 && int'(sRa) > maxAddr) maxAddr = int'(sRa);
         if (cycles == restartAt) setStart(1'b1);
         else if (cycles == restartAt + 1) setStart(1'b0);
         cycles++;
         guard++;
         @(negedge clk);
      end
      setStart(1'b0);
      total++;
      if (cycles !== 10 * n + 1) begin
         bad++;
         $display("FAIL %s_busy_cycles: got %0d, need %0d", tag, cycles, 10 * n + 1);
      end
      total++;
      if (maxAddr > n - 1) begin
         bad++;
         $display("FAIL %s_max_address: got %0d, need <= %0d", tag, maxAddr, n - 1);
      end
      total++;
      if (sDone !== 1'b1 || sFail !== 1'b0 || sFa !== 5'd0 || sFp !== 3'd0 || sBusy !== 1'b0) begin
         bad++;
         $display("FAIL %s_result: got busy=%b done=%b fail=%b fa=%0d fp=%0d, need 0 1 0 0 0",
                  tag, sBusy, sDone, sFail, sFa, sFp);
      end
      @(negedge clk);
      total++;
      if (sDone !== 1'b1 || sFail !== 1'b0 || sBusy !== 1'b0 || sWe !== 1'b0 || sRe !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_sticky: got busy=%b done=%b fail=%b we=%b re=%b, need 0 1 0 0 0",
                  tag, sBusy, sDone, sFail, sWe, sRe);
      end
   endtask

   task automatic test_fault(input int mode, input logic [4:0] expA, input logic [2:0] expP,
                             input int expCycles, input string tag);
      int cycles = 0;
      faultMode = mode;
      sel = 1'b0;
      pulseStart();
      while (sBusy === 1'b1 && cycles < 2000) begin
         cycles++;
         @(negedge clk);
      end
      total++;
      if (cycles !== expCycles) begin
         bad++;
         $display("FAIL %s_busy_cycles: got %0d, need %0d", tag, cycles, expCycles);
      end
      total++;
      if (sDone !== 1'b1 || sFail !== 1'b1 || sFa !== expA || sFp !== expP) begin
         bad++;
         $display("FAIL %s_result: got done=%b fail=%b fa=%0d fp=%0d, need 1 1 %0d %0d",
                  tag, sDone, sFail, sFa, sFp, expA, expP);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (sWe !== 1'b0 || sRe !== 1'b0 || sBusy !== 1'b0 || sFail !== 1'b1) begin
            bad++;
            $display("FAIL %s_quiet_after %0d: got we=%b re=%b busy=%b fail=%b, need 0 0 0 1",
                     tag, i, sWe, sRe, sBusy, sFail);
         end
         @(negedge clk);
      end
      faultMode = 0;
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      pulseStart();
      repeat (163) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      total++;
      if ({sBusy, sDone, sFail, sWe, sRe} !== 5'b0 || sFa !== 5'd0 || sFp !== 3'd0 ||
          sWa !== 5'd0 || sRa !== 5'd0 || sWd !== 8'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b fail=%b we=%b re=%b fa=%0d fp=%0d wa=%0d ra=%0d wd=%h, need all 0",
                  sBusy, sDone, sFail, sWe, sRe, sFa, sFp, sWa, sRa, sWd);
      end
      @(negedge clk);
      reset = 1'b0;
      test_clean(32, -10, "after_reset");
   endtask

   initial begin
      test_reset();
      test_clean(32, -10, "clean32");
      test_fault(1, 5'd5, 3'd1, 44, "stuck1_a5");
      test_fault(2, 5'd7, 3'd2, 112, "stuck0_a7");
      test_fault(3, 5'd4, 3'd1, 42, "alias_3_4");
      test_reset_mid();
      sel = 1'b1;
      test_clean(20, 10, "small20");
      test_clean(20, -10, "small20_again");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Synthesizable March C- built-in self-test controller that drives the write and read ports of a twoPortMem instance and checks the data it reads back.
- Sits beside the memory and shares its single clock. Replaces bench-driven fill/readback with an on-chip initiator and checker.
- Reports pass/fail plus the first failing address and march element.

Parameters:
addresses, 32, number of memory words; must match the attached twoPortMem; any value >= 2, power of two not required
width, 8, data word width; must match twoPortMem
addressWidth, clogb2(addresses), localparam, derived, not user-set

Ports:
clk  input  1  single clock; drives this block and both memory clocks (writeClk, readClk)
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
busy  output  1  high while a test is running
done  output  1  sticky; high from test end until the next accepted start
fail  output  1  sticky; valid when done=1; 1 = mismatch detected
failAddress  output  addressWidth  address of the first mismatch; 0 if none
failPhase  output  3  march element of the first mismatch (encoding below); 0 if none
writeAddress  output  addressWidth  to memory writeAddress
writeEnable  output  1  to memory writeEnable
writeData  output  width  to memory writeData
readAddress  output  addressWidth  to memory readAddress
readEnable  output  1  to memory readEnable
readData  input  width  from memory; valid on the cycle after the read was issued (1-cycle latency)

Behaviour:
- Reset (async assert, released synchronously to clk):
  - All outputs go to 0; FSM goes to IDLE.
  - Reset mid-test aborts immediately. Memory contents are then undefined.
- Data patterns: D0 = all zeros, D1 = all ones (width bits).
- March elements and failPhase encoding:
  - 0 W0 up: write D0.
  - 1 R0W1 up: read expecting D0, then write D1.
  - 2 R1W0 up: read expecting D1, then write D0.
  - 3 R0W1 down: read expecting D0, then write D1.
  - 4 R1W0 down: read expecting D1, then write D0.
  - 5 R0 down: read expecting D0.
- Address order: up = 0..addresses-1; down = addresses-1..0. Wrap is never used; each element ends at its last address.
- Start:
  - start=1 in IDLE: next cycle busy=1, done=0, fail=0, failAddress=0, failPhase=0, and the W0 write to address 0 is driven.
  - start while busy, or while done and not yet restarted, is accepted only from IDLE. DONE returns to IDLE in one cycle, so start is ignored only while busy.
- Timing per element:
  - W0: one write per cycle, N cycles.
  - R-then-W elements: 2 cycles per address.
    - Cycle A: readEnable=1 at address a.
    - Cycle B: writeEnable=1 at address a; readData from cycle A is compared against the expected value in the same cycle.
  - Read and write are never issued at the same address in the same cycle, so read-during-write behaviour is irrelevant.
  - R0 down: one read per cycle; the compare is pipelined one cycle behind. One drain cycle follows the last read.
  - Total busy cycles for a clean run = N + 8N + N + 1 = 10N + 1 (N = addresses).
- Enables: writeEnable and readEnable are 0 whenever no access is issued. Address and data outputs hold their last value when idle.
- Mismatch:
  - On the first compare with readData != expected: capture failAddress and failPhase, issue no further accesses, go to DONE next cycle.
  - In DONE: busy=0, done=1, fail=1.
  - Stop-on-first-fail: later faults are not reported.
- Clean completion: the cycle after the drain compare, busy=0, done=1, fail=0.
- FSM states: IDLE, RUN (element and address counters, A/B sub-step), DRAIN, DONE.
  - DONE goes to IDLE after one cycle; done and fail stay high until the next accepted start.
- Counters: the address counter is addressWidth bits and compares against addresses-1 explicitly, so non-power-of-two sizes never touch out-of-range addresses.

Test Plan:
- Clean run, addresses=32, width=8, real twoPortMem: pulse start -> busy high for exactly 321 cycles, then done=1, fail=0, failAddress=0, failPhase=0. Check read/write address sequence against the element order.
- Stuck-at-1 on readData bit 0 for address 5: first error in element 1 -> done=1, fail=1, failAddress=5, failPhase=1. No writeEnable or readEnable after detection.
- Stuck-at-0 on readData bit 3 for address 7: passes elements 0-1, caught in element 2 -> failAddress=7, failPhase=2.
- Address alias (writes to address 3 also land in address 4): in element 1, reading address 4 returns D1 -> failAddress=4, failPhase=1.
- Reset asserted mid-element 3 -> all outputs 0 asynchronously. New start after reset release -> full clean run, 321 cycles, pass.
- addresses=20: pulse start, then pulse start again during busy (ignored) -> 201 busy cycles, no address >19 ever driven, pass. A subsequent start after done launches a second run.
